baud_gen_rx: RTL and testbench
==============================

BAUD_GEN_RX -- requirements
Module: baud_gen_rx

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL provide parameter FRAME_BITS, default 10, bit periods per frame (start + data + parity + stop); legal range 2..16.
REQ-003 SHALL provide parameter CNT_W, default 16, divider counter width; must hold CLK_FREQ/1200-1.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bps_start  input  1  level; high = frame in progress, low = abort/idle.
REQ-007 baud_sel  input  3  baud select: 0=1200, 1=2400, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
REQ-008 clk_bps  output  1  one-cycle mid-bit sample strobe.
REQ-009 bit_end  output  1  one-cycle strobe at the end of each bit period.
REQ-010 frame_done  output  1  one-cycle strobe after the last bit period of a frame.
REQ-011 busy  output  1  high while in RUN.
REQ-012 bit_idx  output  4  index of the current bit period, 0..FRAME_BITS-1.

Function
REQ-013 SHALL compute per-rate constants at elaboration: DIV = CLK_FREQ/baud - 1 and HALF = DIV/2, both using integer floor (50 MHz, 9600: DIV=5207, HALF=2603).
REQ-014 SHALL implement a two-state FSM: IDLE and RUN.
REQ-015 In IDLE: cnt=0, bit_idx=0, busy=0; bps_start=1 SHALL latch baud_sel into sel_r and enter RUN with cnt=0 on the same edge.
REQ-016 In RUN: cnt SHALL increment by 1 each cycle; at cnt==DIV[sel_r], cnt SHALL wrap to 0.
REQ-017 clk_bps SHALL be registered and high for exactly the one cycle following a cycle with RUN and cnt==HALF[sel_r].
REQ-018 bit_end SHALL be registered and high for exactly the one cycle following a cycle with RUN and cnt==DIV[sel_r].
REQ-019 On wrap with bit_idx<FRAME_BITS-1, bit_idx SHALL increment.
REQ-020 On wrap with bit_idx==FRAME_BITS-1: frame_done SHALL pulse (registered, concurrent with that bit_end), FSM SHALL return to IDLE, bit_idx SHALL clear to 0.
REQ-021 With bps_start still high after frame_done, SHALL re-enter RUN on the next edge (one IDLE cycle between frames).
REQ-022 bps_start=0 in RUN SHALL abort: next state IDLE, cnt=0, bit_idx=0, no further clk_bps/bit_end/frame_done.
REQ-023 Abort coincident with the final wrap SHALL take priority: no frame_done, no bit_end.
REQ-024 baud_sel changes during RUN SHALL be ignored until the next IDLE->RUN transition.
REQ-025 busy SHALL be registered and equal to (state==RUN).
REQ-026 Exactly FRAME_BITS clk_bps pulses and FRAME_BITS bit_end pulses SHALL occur per completed frame.

Reset
REQ-027 rst=1 SHALL force state=IDLE, cnt=0, sel_r=0, bit_idx=0, clk_bps=0, bit_end=0, frame_done=0, busy=0 on the next edge; rst SHALL override bps_start.
REQ-028 Reset asserted mid-frame SHALL discard the frame without any strobe; after release, operation SHALL resume from IDLE.

Verification
REQ-029 Defaults, baud_sel=3, bps_start held high for one frame -> first clk_bps 2604 cycles after the start edge; bit_end spacing 5208 cycles; 10 clk_bps; frame_done with the 10th bit_end; busy low for 1 cycle.
REQ-030 baud_sel=7 -> DIV=433, HALF=216; clk_bps spacing 434 cycles; baud_sel=0 -> DIV=41665, no counter overflow.
REQ-031 bps_start dropped after 3 bit_ends -> busy low next cycle, bit_idx=0, no frame_done, no further strobes.
REQ-032 bps_start dropped in the cycle of the final wrap -> no frame_done and no 10th bit_end.
REQ-033 baud_sel toggled 3->7 mid-frame -> spacing stays 5208 until the frame ends; the next frame uses 434.
REQ-034 rst pulsed for 1 cycle at cnt=1000 -> all outputs 0 next cycle; with bps_start high, RUN re-entered the cycle after rst releases.

Source files
------------

// File: rtl/baud_gen_rx.sv
// Purpose: UART receive baud generator with mid-bit sample strobe, bit-end strobe and frame tracking.
// Latency: all strobes registered; first clk_bps arrives HALF+1 cycles after the IDLE->RUN edge.
// Backpressure: none; bps_start low aborts the frame immediately with no further strobes.
module baud_gen_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int FRAME_BITS = 10,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bps_start,
  input  logic [2:0] baud_sel,
  output logic       clk_bps,
  output logic       bit_end,
  output logic       frame_done,
  output logic       busy,
  output logic [3:0] bit_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

  // Baud rate for each select code.
  function automatic int baud_of(input logic [2:0] s);
    case (s)
      3'd0:    return 1200;
      3'd1:    return 2400;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Terminal count of the divider: one bit period is DIV+1 clocks.
  function automatic logic [CNT_W-1:0] div_of(input logic [2:0] s);
    return CNT_W'(CLK_FREQ / baud_of(s) - 1);
  endfunction

  // Mid-bit point of the divider.
  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] s);
    return CNT_W'((CLK_FREQ / baud_of(s) - 1) / 2);
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       sel_r, sel_n;
  logic [3:0]       idx_n;
  logic             bps_n, be_n, fd_n;
  logic [CNT_W-1:0] div_r, half_r;

  // Rate constants fold to a small mux of constants on the latched select.
  assign div_r  = div_of(sel_r);
  assign half_r = half_of(sel_r);

  // Next-state and strobe decode; an abort suppresses every strobe of that cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_r;
    idx_n   = bit_idx;
    bps_n   = 1'b0;
    be_n    = 1'b0;
    fd_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = 4'd0;
        if (bps_start) begin
          state_n = RUN;
          sel_n   = baud_sel;
        end
      end
      RUN: begin
        if (!bps_start) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = 4'd0;
        end else begin
          bps_n = (cnt == half_r);
          if (cnt == div_r) begin
            cnt_n = '0;
            be_n  = 1'b1;
            if (bit_idx == LAST_IDX) begin
              fd_n    = 1'b1;
              state_n = IDLE;
              idx_n   = 4'd0;
            end else begin
              idx_n = bit_idx + 4'd1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = 4'd0;
      end
    endcase
  end

  // State, counter and registered outputs; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_r      <= 3'd0;
      bit_idx    <= 4'd0;
      clk_bps    <= 1'b0;
      bit_end    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel_r      <= sel_n;
      bit_idx    <= idx_n;
      clk_bps    <= bps_n;
      bit_end    <= be_n;
      frame_done <= fd_n;
      busy       <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_baud_gen_rx.sv
// Bench for baud_gen_rx: every cycle is compared against an edge-count reference model,
// plus a latency table per baud select and hand-written abort/reset/retune sequences.
// Runs with a 4-bit frame at the default 50 MHz clock to keep the run short.
module tb_baud_gen_rx;

  localparam int CLK_FREQ = 50000000;
  localparam int FB       = 4;
  localparam int BAUD_TAB [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

  logic       clk = 1'b0;
  logic       rst;
  logic       bps_start;
  logic [2:0] baud_sel;
  logic       clk_bps, bit_end, frame_done, busy;
  logic [3:0] bit_idx;

  baud_gen_rx #(.CLK_FREQ(CLK_FREQ), .FRAME_BITS(FB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bps_start(bps_start), .baud_sel(baud_sel),
    .clk_bps(clk_bps), .bit_end(bit_end), .frame_done(frame_done),
    .busy(busy), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    int         lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_bps  = 0;
  int n_be   = 0;
  int n_fd   = 0;

  // Reference model: edges counted since the start edge, outputs by modulo arithmetic.
  bit   m_run = 1'b0;
  int   m_n, m_p, m_h;
  logic [7:0] e_vec = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Predict the outputs that will follow the next rising edge from the current inputs.
  task automatic model_step();
    bit e_bps, e_be, e_fd, e_busy;
    int e_idx;
    e_bps = 0; e_be = 0; e_fd = 0; e_busy = 0; e_idx = 0;
    if (rst) begin
      m_run = 0;
    end else if (!m_run) begin
      if (bps_start) begin
        m_run = 1;
        m_n   = 0;
        m_p   = CLK_FREQ / BAUD_TAB[baud_sel];
        m_h   = (m_p - 1) / 2;
      end
      e_busy = m_run;
    end else if (!bps_start) begin
      m_run = 0;
    end else begin
      m_n++;
      e_bps = ((m_n - 1) % m_p == m_h);
      e_be  = (m_n % m_p == 0);
      e_fd  = (m_n == FB * m_p);
      if (e_fd) m_run = 0;
      else e_idx = m_n / m_p;
      e_busy = m_run;
    end
    e_vec = {e_bps, e_be, e_fd, e_busy, 4'(e_idx)};
  endtask

  function automatic int out_vec();
    return int'({clk_bps, bit_end, frame_done, busy, bit_idx});
  endfunction

  // One clock: model prediction, edge, compare, strobe bookkeeping.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("cycle_outputs", out_vec(), int'(e_vec));
    if (clk_bps)    n_bps++;
    if (bit_end)    n_be++;
    if (frame_done) n_fd++;
  endtask

  // Advance until the selected strobe is seen; t = cycle of the hit, -1 on timeout.
  task automatic wait_for(input int which, input int bound, output int t);
    t = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if ((which == 0 && clk_bps) || (which == 1 && bit_end) || (which == 2 && frame_done)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("wait_timeout", 0, 1);
  endtask

  task automatic go_idle();
    bps_start = 1'b0;
    tick();
    tick();
  endtask

  vec_t vt [6];

  initial begin
    int t, t0, prev, b_bps, b_be, b_fd;

    vt[0] = '{3'd0, 20833};
    vt[1] = '{3'd3, 2604};
    vt[2] = '{3'd4, 1302};
    vt[3] = '{3'd5, 651};
    vt[4] = '{3'd6, 434};
    vt[5] = '{3'd7, 217};

    rst = 1'b1; bps_start = 1'b0; baud_sel = 3'd0;
    tick();
    check("reset_state", out_vec(), 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_reset", out_vec(), 0);

    // First mid-bit strobe latency for each baud select.
    for (int i = 0; i < 6; i++) begin
      go_idle();
      baud_sel = vt[i].sel;
      bps_start = 1'b1;
      tick();
      t0 = cyc;
      check("start_busy", int'(busy), 1);
      baud_sel = 3'($urandom_range(0, 7));
      wait_for(0, 25000, t);
      check($sformatf("first_bps_sel%0d", vt[i].sel), t - t0, vt[i].lat);
    end

    // Full frame at 9600, retuned to 115200 mid-frame, then back-to-back frame.
    go_idle();
    baud_sel = 3'd3; bps_start = 1'b1;
    tick();
    t0 = cyc; b_bps = n_bps; b_be = n_be; b_fd = n_fd;
    wait_for(0, 6000, t);
    check("frame_first_bps", t - t0, 2604);
    wait_for(1, 6000, t);
    check("frame_first_bit_end", t - t0, 5208);
    baud_sel = 3'd7;
    for (int i = 0; i < FB - 1; i++) begin
      prev = t;
      wait_for(1, 6000, t);
      check("bit_end_spacing", t - prev, 5208);
    end
    check("frame_done_with_last_bit_end", int'(frame_done), 1);
    check("busy_low_at_frame_end", int'(busy), 0);
    check("bps_per_frame", n_bps - b_bps, FB);
    check("bit_end_per_frame", n_be - b_be, FB);
    check("frame_done_per_frame", n_fd - b_fd, 1);
    tick();
    check("rerun_after_one_idle", int'(busy), 1);
    t0 = cyc;
    wait_for(0, 1000, t);
    check("next_frame_first_bps", t - t0, 217);
    wait_for(1, 1000, t);
    check("next_frame_bit_end", t - t0, 434);

    // Abort after three bit_ends.
    go_idle();
    baud_sel = 3'd7; bps_start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) wait_for(1, 1000, t);
    bps_start = 1'b0;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_bit_idx", int'(bit_idx), 0);
    b_bps = n_bps; b_be = n_be; b_fd = n_fd;
    for (int i = 0; i < 1000; i++) tick();
    check("abort_no_strobes", (n_bps - b_bps) + (n_be - b_be) + (n_fd - b_fd), 0);

    // Abort coincident with the final wrap.
    baud_sel = 3'd7; bps_start = 1'b1;
    tick();
    b_be = n_be; b_fd = n_fd;
    for (int i = 0; i < FB * 434 - 1; i++) tick();
    bps_start = 1'b0;
    tick();
    check("final_abort_bit_end", int'(bit_end), 0);
    check("final_abort_frame_done", int'(frame_done), 0);
    for (int i = 0; i < 4; i++) tick();
    check("final_abort_bit_end_count", n_be - b_be, FB - 1);
    check("final_abort_frame_done_count", n_fd - b_fd, 0);

    // Reset pulse mid-frame at cnt=1000 with bps_start held high.
    baud_sel = 3'd3; bps_start = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) tick();
    rst = 1'b1;
    tick();
    check("mid_reset_outputs", out_vec(), 0);
    rst = 1'b0;
    tick();
    check("run_after_reset", int'(busy), 1);
    t0 = cyc;
    wait_for(0, 6000, t);
    check("post_reset_first_bps", t - t0, 2604);

    // Randomized traffic on the faster rates, checked cycle by cycle.
    go_idle();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 20) baud_sel = 3'($urandom_range(5, 7));
      bps_start = ($urandom_range(0, 699) != 0);
      rst = ($urandom_range(0, 2999) == 0);
      tick();
    end
    rst = 1'b0;
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
